// File: rtl/uart_rx_fsm.sv
// UART receive front end: start detect, 3-sample majority vote, LSB-first shift,
// optional parity via an external checker, stop check. Optional input sync: UART_RX_SYNC_EN.
module uart_rx_fsm #(
   parameter int DATA_WIDTH     = 8,
   parameter int PRESCALE_WIDTH = 6
) (
   input  logic                      CLK,
   input  logic                      RST,
   input  logic                      RX_IN,
   input  logic [PRESCALE_WIDTH-1:0] Prescale,
   input  logic                      PAR_EN,
   input  logic                      PAR_TYP,
   input  logic                      parity_Error,
   output logic                      parity_check_Enable,
   output logic                      parity_Sampled_bit,
   output logic                      parity_type,
   output logic [DATA_WIDTH-1:0]     parity_P_Data,
   output logic [DATA_WIDTH-1:0]     P_DATA,
   output logic                      data_valid,
   output logic                      Par_Err,
   output logic                      Stp_Err
);

   // state  | meaning
   // IDLE   | line idle, waiting for RX low
   // START  | start bit, glitch rejected at bit end
   // DATA   | DATA_WIDTH data bits, LSB first
   // PARITY | parity bit, checker enabled at bit end
   // STOP   | stop bit, frame result issued at bit end
   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

   localparam int BW = $clog2(DATA_WIDTH + 1);

   state_t                    r_state;
   logic [PRESCALE_WIDTH-1:0] r_edge_cnt;
   logic [PRESCALE_WIDTH-1:0] r_pre;
   logic [BW-1:0]             r_bit_cnt;
   logic [2:0]                r_samp;
   logic                      r_par_en;
   logic                      r_par_typ;
   logic                      r_par_fail;
   logic                      r_chk_en;
   logic [DATA_WIDTH-1:0]     r_shift;
   logic [DATA_WIDTH-1:0]     r_data;
   logic                      r_dv;
   logic                      r_perr;
   logic                      r_serr;

   logic                      w_rx;
   logic                      w_vote;
   logic                      w_bit_end;
   logic                      w_pre_end;
   logic [PRESCALE_WIDTH-1:0] w_half;

`ifdef UART_RX_SYNC_EN
   logic [1:0] r_sync;
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) r_sync <= 2'b11;
      else      r_sync <= {r_sync[0], RX_IN};
   end
   assign w_rx = r_sync[1];
`else
   assign w_rx = RX_IN;
`endif

   assign w_half    = r_pre >> 1;
   assign w_bit_end = (r_edge_cnt == r_pre - PRESCALE_WIDTH'(1));
   assign w_pre_end = (r_edge_cnt == r_pre - PRESCALE_WIDTH'(2));
   assign w_vote    = (r_samp[0] & r_samp[1]) | (r_samp[0] & r_samp[2]) | (r_samp[1] & r_samp[2]);

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_state    <= S_IDLE;
         r_edge_cnt <= '0;
         r_pre      <= '0;
         r_bit_cnt  <= '0;
         r_samp     <= '0;
         r_par_en   <= 1'b0;
         r_par_typ  <= 1'b0;
         r_par_fail <= 1'b0;
         r_chk_en   <= 1'b0;
         r_shift    <= '0;
         r_data     <= '0;
         r_dv       <= 1'b0;
         r_perr     <= 1'b0;
         r_serr     <= 1'b0;
      end else begin
         r_dv     <= 1'b0;
         r_perr   <= 1'b0;
         r_serr   <= 1'b0;
         // Raised one cycle early so the checker sees it exactly at edge P-1
         r_chk_en <= (r_state == S_PARITY) && w_pre_end;

         if (r_state != S_IDLE) begin
            if (r_edge_cnt == w_half - PRESCALE_WIDTH'(1)) r_samp[0] <= w_rx;
            if (r_edge_cnt == w_half)                      r_samp[1] <= w_rx;
            if (r_edge_cnt == w_half + PRESCALE_WIDTH'(1)) r_samp[2] <= w_rx;
            if (w_bit_end) r_edge_cnt <= '0;
            else           r_edge_cnt <= r_edge_cnt + PRESCALE_WIDTH'(1);
         end

         case (r_state)
            S_IDLE: begin
               if (!w_rx) begin
                  r_state    <= S_START;
                  r_edge_cnt <= PRESCALE_WIDTH'(1);
                  r_pre      <= Prescale;
                  r_par_en   <= PAR_EN;
                  r_par_typ  <= PAR_TYP;
                  r_par_fail <= 1'b0;
               end
            end
            S_START: begin
               if (w_bit_end) begin
                  r_bit_cnt <= '0;
                  r_state   <= w_vote ? S_IDLE : S_DATA;
               end
            end
            S_DATA: begin
               if (w_bit_end) begin
                  r_shift   <= {w_vote, r_shift[DATA_WIDTH-1:1]};
                  r_bit_cnt <= r_bit_cnt + BW'(1);
                  if (r_bit_cnt == BW'(DATA_WIDTH - 1))
                     r_state <= r_par_en ? S_PARITY : S_STOP;
               end
            end
            S_PARITY: begin
               if (w_bit_end) begin
                  r_par_fail <= parity_Error;
                  r_state    <= S_STOP;
               end
            end
            S_STOP: begin
               if (w_bit_end) begin
                  if (r_par_fail || !w_vote) begin
                     r_perr <= r_par_fail;
                     r_serr <= !w_vote;
                  end else begin
                     r_data <= r_shift;
                     r_dv   <= 1'b1;
                  end
                  // A low line on the last stop edge is the next start bit's edge 0
                  if (!w_rx) begin
                     r_state    <= S_START;
                     r_edge_cnt <= PRESCALE_WIDTH'(1);
                     r_pre      <= Prescale;
                     r_par_en   <= PAR_EN;
                     r_par_typ  <= PAR_TYP;
                     r_par_fail <= 1'b0;
                  end else begin
                     r_state <= S_IDLE;
                  end
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign parity_check_Enable = r_chk_en;
   assign parity_Sampled_bit  = w_vote;
   assign parity_type         = r_par_typ;
   assign parity_P_Data       = r_shift;
   assign P_DATA              = r_data;
   assign data_valid          = r_dv;
   assign Par_Err             = r_perr;
   assign Stp_Err             = r_serr;

endmodule

// File: tb/tb_uart_rx_fsm.sv
// Self-checking bench for uart_rx_fsm: vector table, hand sequences for
// glitch / back-to-back / mid-frame reset, then random frames against a frame-level model.
module tb_uart_rx_fsm;

   logic       CLK = 1'b0;
   logic       RST = 1'b0;
   logic       RX_IN = 1'b1;
   logic [5:0] Prescale = 6'd8;
   logic       PAR_EN = 1'b0;
   logic       PAR_TYP = 1'b0;
   logic       parity_Error;
   logic       parity_check_Enable;
   logic       parity_Sampled_bit;
   logic       parity_type;
   logic [7:0] parity_P_Data;
   logic [7:0] P_DATA;
   logic       data_valid;
   logic       Par_Err;
   logic       Stp_Err;

   uart_rx_fsm #(.DATA_WIDTH(8), .PRESCALE_WIDTH(6)) dut (
      .CLK(CLK), .RST(RST), .RX_IN(RX_IN), .Prescale(Prescale),
      .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .parity_Error(parity_Error),
      .parity_check_Enable(parity_check_Enable), .parity_Sampled_bit(parity_Sampled_bit),
      .parity_type(parity_type), .parity_P_Data(parity_P_Data),
      .P_DATA(P_DATA), .data_valid(data_valid), .Par_Err(Par_Err), .Stp_Err(Stp_Err)
   );

   // External combinational parity checker: data plus parity bit must have
   // an even (type 0) or odd (type 1) number of ones.
   assign parity_Error = parity_check_Enable &&
                         (($countones({parity_P_Data, parity_Sampled_bit}) % 2) != int'(parity_type));

   always #5 CLK = ~CLK;

   int         checks = 0;
   int         errors = 0;
   int         cyc = 0;
   int         t0 = 0;
   int         n_perr = 0;
   int         n_serr = 0;
   int         n_chk = 0;
   logic [7:0] dv_data_q[$];
   int         dv_cyc_q[$];
   logic [7:0] exp_pd = 8'h00;

   always @(posedge CLK) cyc <= cyc + 1;

   always @(negedge CLK) begin
      if (data_valid) begin
         dv_data_q.push_back(P_DATA);
         dv_cyc_q.push_back(cyc);
      end
      if (Par_Err) n_perr++;
      if (Stp_Err) n_serr++;
      if (parity_check_Enable) n_chk++;
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached (got running, want finished)");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
      end
   endtask

   task automatic drive_bit(input logic b, input int p);
      RX_IN = b;
      repeat (p) @(posedge CLK);
      #1;
   endtask

   task automatic send_frame(input logic [7:0] d, input logic pe, input logic pt,
                             input logic pb, input logic st, input int p);
      Prescale = 6'(p);
      PAR_EN   = pe;
      PAR_TYP  = pt;
      t0       = cyc;
      drive_bit(1'b0, p);
      for (int i = 0; i < 8; i++) drive_bit(d[i], p);
      if (pe) drive_bit(pb, p);
      drive_bit(st, p);
      RX_IN = 1'b1;
   endtask

   task automatic run_frame(input string tag, input logic [7:0] d, input logic pe, input logic pt,
                            input logic pb, input logic st, input int p,
                            input logic e_dv, input logic e_pe, input logic e_se, input logic [7:0] e_pd);
      int s_dv, s_pe, s_se, s_ck;
      s_dv = dv_data_q.size();
      s_pe = n_perr;
      s_se = n_serr;
      s_ck = n_chk;
      send_frame(d, pe, pt, pb, st, p);
      repeat (p + 4) @(posedge CLK);
      #1;
      check($sformatf("%s_dv_count", tag), dv_data_q.size() - s_dv, int'(e_dv));
      check($sformatf("%s_par_err_count", tag), n_perr - s_pe, int'(e_pe));
      check($sformatf("%s_stp_err_count", tag), n_serr - s_se, int'(e_se));
      check($sformatf("%s_chk_en_cycles", tag), n_chk - s_ck, int'(pe));
      check($sformatf("%s_P_DATA", tag), int'(P_DATA), int'(e_pd));
      if (e_dv && dv_data_q.size() > s_dv) begin
         check($sformatf("%s_latency", tag), dv_cyc_q[$] - t0, (10 + int'(pe)) * p);
         check($sformatf("%s_dv_data", tag), int'(dv_data_q[$]), int'(e_pd));
      end
   endtask

   function automatic void ref_model(input logic [7:0] d, input logic pe, input logic pt,
                                     input logic pb, input logic st, input logic [7:0] prev,
                                     output logic e_dv, output logic e_pe, output logic e_se,
                                     output logic [7:0] e_pd);
      int ones;
      ones = $countones(d) + int'(pb);
      e_pe = pe && ((ones % 2) != int'(pt));
      e_se = !st;
      e_dv = !e_pe && !e_se;
      e_pd = e_dv ? d : prev;
   endfunction

   typedef struct {
      logic [7:0] d;
      logic       pe, pt, pb, st;
      int         p;
      logic       e_dv, e_pe, e_se;
      logic [7:0] e_pd;
   } vec_t;

   vec_t vecs[9];

   initial begin
      int         s_dv, s_pe, s_se;
      logic [7:0] d;
      logic       pe, pt, pb, st, e_dv, e_pe, e_se;
      logic [7:0] e_pd;
      int         p;

      //             data   pe    pt    pb    stop  P   dv    perr  serr  P_DATA
      vecs[0] = '{8'hA5, 1'b1, 1'b0, 1'b0, 1'b1, 8,  1'b1, 1'b0, 1'b0, 8'hA5};
      vecs[1] = '{8'hA5, 1'b1, 1'b0, 1'b1, 1'b1, 8,  1'b0, 1'b1, 1'b0, 8'hA5};
      vecs[2] = '{8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 16, 1'b0, 1'b0, 1'b1, 8'hA5};
      vecs[3] = '{8'h3C, 1'b0, 1'b0, 1'b0, 1'b1, 16, 1'b1, 1'b0, 1'b0, 8'h3C};
      vecs[4] = '{8'h5A, 1'b1, 1'b1, 1'b1, 1'b1, 32, 1'b1, 1'b0, 1'b0, 8'h5A};
      vecs[5] = '{8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 8,  1'b0, 1'b1, 1'b1, 8'h5A};
      vecs[6] = '{8'hFF, 1'b1, 1'b0, 1'b0, 1'b1, 16, 1'b1, 1'b0, 1'b0, 8'hFF};
      vecs[7] = '{8'hC3, 1'b1, 1'b1, 1'b0, 1'b1, 8,  1'b0, 1'b1, 1'b0, 8'hFF};
      vecs[8] = '{8'h01, 1'b0, 1'b1, 1'b1, 1'b1, 8,  1'b1, 1'b0, 1'b0, 8'h01};

      #3;
      check("rst_P_DATA", int'(P_DATA), 0);
      check("rst_data_valid", int'(data_valid), 0);
      check("rst_Par_Err", int'(Par_Err), 0);
      check("rst_Stp_Err", int'(Stp_Err), 0);
      check("rst_chk_en", int'(parity_check_Enable), 0);
      repeat (3) @(posedge CLK);
      #1 RST = 1'b1;
      repeat (4) @(posedge CLK);
      #1;

      for (int i = 0; i < 9; i++) begin
         run_frame($sformatf("vec%0d", i), vecs[i].d, vecs[i].pe, vecs[i].pt, vecs[i].pb,
                   vecs[i].st, vecs[i].p, vecs[i].e_dv, vecs[i].e_pe, vecs[i].e_se, vecs[i].e_pd);
      end
      exp_pd = 8'h01;

      // Start glitch: 3 low cycles at P=16 must be rejected silently
      Prescale = 6'd16;
      PAR_EN   = 1'b0;
      s_dv = dv_data_q.size(); s_pe = n_perr; s_se = n_serr;
      RX_IN = 1'b0;
      repeat (3) @(posedge CLK);
      #1 RX_IN = 1'b1;
      repeat (24) @(posedge CLK);
      #1;
      check("glitch_dv", dv_data_q.size() - s_dv, 0);
      check("glitch_errs", (n_perr - s_pe) + (n_serr - s_se), 0);
      check("glitch_P_DATA", int'(P_DATA), int'(exp_pd));
      run_frame("after_glitch", 8'h96, 1'b0, 1'b0, 1'b0, 1'b1, 16, 1'b1, 1'b0, 1'b0, 8'h96);
      exp_pd = 8'h96;

      // Back-to-back frames at P=32 with no idle gap
      s_dv = dv_data_q.size();
      send_frame(8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 32);
      send_frame(8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, 32);
      repeat (40) @(posedge CLK);
      #1;
      check("b2b_dv_count", dv_data_q.size() - s_dv, 2);
      if (dv_data_q.size() - s_dv == 2) begin
         check("b2b_first", int'(dv_data_q[s_dv]), 8'h00);
         check("b2b_second", int'(dv_data_q[s_dv + 1]), 8'hFF);
         check("b2b_spacing", dv_cyc_q[s_dv + 1] - dv_cyc_q[s_dv], 10 * 32);
      end
      exp_pd = 8'hFF;

      // Reset during data bit 4 of 0x5A aborts the frame
      Prescale = 6'd8;
      PAR_EN   = 1'b0;
      d = 8'h5A;
      s_dv = dv_data_q.size(); s_pe = n_perr; s_se = n_serr;
      drive_bit(1'b0, 8);
      for (int i = 0; i < 4; i++) drive_bit(d[i], 8);
      RX_IN = d[4];
      repeat (4) @(posedge CLK);
      #1 RST = 1'b0;
      #1;
      check("midrst_P_DATA", int'(P_DATA), 0);
      repeat (3) @(posedge CLK);
      #1 RX_IN = 1'b1;
      RST = 1'b1;
      repeat (20) @(posedge CLK);
      #1;
      check("midrst_no_dv", dv_data_q.size() - s_dv, 0);
      check("midrst_no_errs", (n_perr - s_pe) + (n_serr - s_se), 0);
      exp_pd = 8'h00;
      run_frame("after_rst", 8'h81, 1'b0, 1'b0, 1'b0, 1'b1, 8, 1'b1, 1'b0, 1'b0, 8'h81);
      exp_pd = 8'h81;

      // Random frames against the frame-level model
      for (int n = 0; n < 40; n++) begin
         d  = 8'($urandom_range(0, 255));
         p  = 8 << $urandom_range(0, 2);
         pe = 1'($urandom_range(0, 1));
         pt = 1'($urandom_range(0, 1));
         pb = 1'($urandom_range(0, 1));
         st = ($urandom_range(0, 5) != 0);
         ref_model(d, pe, pt, pb, st, exp_pd, e_dv, e_pe, e_se, e_pd);
         run_frame($sformatf("rnd%0d", n), d, pe, pt, pb, st, p, e_dv, e_pe, e_se, e_pd);
         exp_pd = e_pd;
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
